// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI shift engine.
package spi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLead,
        StXfer,
        StTrail
    } spi_state_e;

    // Mode encoding is {cpol, cpha}.
    localparam logic [1:0] SpiMode0 = 2'b00;
    localparam logic [1:0] SpiMode1 = 2'b01;
    localparam logic [1:0] SpiMode2 = 2'b10;
    localparam logic [1:0] SpiMode3 = 2'b11;

    function automatic int unsigned eff_len(input int unsigned len, input int unsigned max_len);
        return ((len == 0) || (len > max_len)) ? max_len : len;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period timer for the SPI engine: ticks once per half-period and owns the SCLK register.
module spi_clkgen #(
    parameter int unsigned CLKDIV_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                clr_i,
    input  logic                toggle_i,
    input  logic                idle_lvl_i,
    input  logic [CLKDIV_W-1:0] div_i,
    output logic                tick_o,
    output logic                sclk_o
);

    logic [CLKDIV_W-1:0] cnt_q;
    logic                sclk_q;

    assign tick_o = en_i && (cnt_q == div_i);
    assign sclk_o = sclk_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q  <= '0;
            sclk_q <= idle_lvl_i;
        end else if (en_i) begin
            if (tick_o) begin
                cnt_q <= '0;
                if (toggle_i) begin
                    sclk_q <= ~sclk_q;
                end
            end else begin
                cnt_q <= cnt_q + CLKDIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI master shift engine: one frame per valid/ready handshake, all four modes,
// MSB/LSB ordering and run-time frame length.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned CLKDIV_W  = 8,
    parameter int unsigned LENW      = $clog2(DATAWIDTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic [DATAWIDTH-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    input  logic [LENW-1:0]      len_i,
    input  logic                 lsb_first_i,
    input  logic                 cpol_i,
    input  logic                 cpha_i,
    input  logic [CLKDIV_W-1:0]  clk_div_i,
    output logic                 sclk_o,
    output logic                 cs_n_o,
    output logic                 mosi_o,
    input  logic                 miso_i,
    output logic [DATAWIDTH-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 busy_o
);

    spi_state_e state_q, state_d;

    logic [DATAWIDTH-1:0] tx_sr_q, rx_sr_q, rx_data_q;
    logic [DATAWIDTH-1:0] aligned, rx_result;
    logic [LENW-1:0]      len_q, len_eff;
    logic [LENW:0]        edge_cnt_q, edge_nxt;
    logic [CLKDIV_W-1:0]  div_q;
    logic [1:0]           mode_q;
    logic                 lsb_q;
    logic                 mosi_q, cs_n_q, busy_q, rx_valid_q;
    logic                 tick, accept, xfer_tick, odd_edge, last_edge;
    logic                 sample_odd, sample_edge, shift_edge;

    assign len_eff = LENW'(eff_len(32'(len_i), DATAWIDTH));

    // MSB-first frames are left-justified so the next bit is always at the top.
    assign aligned   = lsb_first_i ? tx_data_i
                                   : tx_data_i << (DATAWIDTH - 32'(len_eff));
    assign rx_result = lsb_q ? rx_sr_q >> (DATAWIDTH - 32'(len_q)) : rx_sr_q;

    assign accept     = tx_valid_i && (state_q == StIdle);
    assign xfer_tick  = tick && (state_q == StXfer);
    assign edge_nxt   = edge_cnt_q + (LENW + 1)'(1);
    assign odd_edge   = ~edge_cnt_q[0];
    assign last_edge  = (edge_nxt == {len_q, 1'b0});
    assign sample_odd = (mode_q == SpiMode0) || (mode_q == SpiMode2);

    // With CPHA=0 the final edge only restores the idle level and must not shift.
    assign sample_edge = xfer_tick && (sample_odd ? odd_edge : ~odd_edge);
    assign shift_edge  = xfer_tick && (sample_odd ? (~odd_edge && !last_edge) : odd_edge);

    spi_clkgen #(
        .CLKDIV_W(CLKDIV_W)
    ) u_clkgen (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .en_i       (state_q != StIdle),
        .clr_i      (state_q == StIdle),
        .toggle_i   (state_q == StXfer),
        .idle_lvl_i (cpol_i),
        .div_i      (div_q),
        .tick_o     (tick),
        .sclk_o     (sclk_o)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (tx_valid_i)        state_d = StLead;
            StLead:  if (tick)              state_d = StXfer;
            StXfer:  if (tick && last_edge) state_d = StTrail;
            StTrail: if (tick)              state_d = StIdle;
            default:                        state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            len_q      <= '0;
            edge_cnt_q <= '0;
            div_q      <= '0;
            mode_q     <= SpiMode0;
            lsb_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            cs_n_q     <= (state_d == StIdle);
            busy_q     <= (state_d != StIdle);
            rx_valid_q <= (state_q == StTrail) && tick;
            if (accept) begin
                len_q      <= len_eff;
                lsb_q      <= lsb_first_i;
                mode_q     <= {cpol_i, cpha_i};
                div_q      <= clk_div_i;
                edge_cnt_q <= '0;
                rx_sr_q    <= '0;
                if (!cpha_i) begin
                    mosi_q  <= lsb_first_i ? aligned[0] : aligned[DATAWIDTH-1];
                    tx_sr_q <= lsb_first_i ? aligned >> 1 : aligned << 1;
                end else begin
                    tx_sr_q <= aligned;
                end
            end else if (xfer_tick) begin
                edge_cnt_q <= edge_nxt;
                if (sample_edge) begin
                    rx_sr_q <= lsb_q ? {miso_i, rx_sr_q[DATAWIDTH-1:1]}
                                     : {rx_sr_q[DATAWIDTH-2:0], miso_i};
                end
                if (shift_edge) begin
                    mosi_q  <= lsb_q ? tx_sr_q[0] : tx_sr_q[DATAWIDTH-1];
                    tx_sr_q <= lsb_q ? tx_sr_q >> 1 : tx_sr_q << 1;
                end
            end else if ((state_q == StTrail) && tick) begin
                rx_data_q <= rx_result;
                mosi_q    <= 1'b0;
            end
        end
    end

    assign tx_ready_o = (state_q == StIdle);
    assign cs_n_o     = cs_n_q;
    assign mosi_o     = mosi_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed, table-driven bench for spi_shift_engine with a bench-side SPI slave model.
module tb_spi_shift_engine;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data_i = '0;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o;
    logic [3:0] len_i = 4'd8;
    logic       lsb_first_i = 1'b0;
    logic       cpol_i = 1'b0;
    logic       cpha_i = 1'b0;
    logic [7:0] clk_div_i = '0;
    logic       sclk_o, cs_n_o, mosi_o, miso_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, busy_o;

    logic loop_en = 1'b0;
    logic slave_miso = 1'b0;
    assign miso_i = loop_en ? mosi_o : slave_miso;

    always #5 clk_i = ~clk_i;

    spi_shift_engine #(
        .DATAWIDTH(8),
        .CLKDIV_W (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .tx_data_i   (tx_data_i),
        .tx_valid_i  (tx_valid_i),
        .tx_ready_o  (tx_ready_o),
        .len_i       (len_i),
        .lsb_first_i (lsb_first_i),
        .cpol_i      (cpol_i),
        .cpha_i      (cpha_i),
        .clk_div_i   (clk_div_i),
        .sclk_o      (sclk_o),
        .cs_n_o      (cs_n_o),
        .mosi_o      (mosi_o),
        .miso_i      (miso_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .busy_o      (busy_o)
    );

    typedef struct packed {
        logic       cpol;
        logic       cpha;
        logic       lsb;
        logic [3:0] len;
        logic [7:0] div;
        logic [7:0] tx;
        logic [7:0] pat;
        int         eff_l;
        logic [7:0] exp_rx;
        logic [7:0] exp_mosi;
        int         exp_cslow;
        int         exp_edges;
    } vec_t;

    vec_t vecs[8];
    int   n_checks = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic slave_bit(input vec_t v, input int k);
        return v.lsb ? v.pat[k] : v.pat[v.eff_l - 1 - k];
    endfunction

    task automatic run_frame(input int id, input vec_t v);
        int   k, sc, edges, cslow, rx_cyc;
        logic prev, got;
        logic [7:0] mw;
        string tag;
        tag = $sformatf("v%0d", id);
        @(negedge clk_i);
        cpol_i = v.cpol; cpha_i = v.cpha; lsb_first_i = v.lsb; len_i = v.len;
        clk_div_i = v.div; tx_data_i = v.tx; tx_valid_i = 1'b1;
        k = 0; sc = 0; edges = 0; cslow = 0; mw = '0; got = 1'b0; rx_cyc = -1;
        if (!v.cpha) begin
            slave_miso = slave_bit(v, 0);
            k = 1;
        end
        @(negedge clk_i);
        // Everything below must be ignored until the frame completes.
        tx_valid_i = 1'b0; tx_data_i = ~v.tx; lsb_first_i = ~v.lsb; cpha_i = ~v.cpha;
        cpol_i = ~v.cpol; len_i = 4'd3; clk_div_i = v.div + 8'd5;
        check({tag, " start cs_n"}, 32'(cs_n_o), 32'd0);
        check({tag, " start ready/busy"}, {30'd0, tx_ready_o, busy_o}, 32'b01);
        check({tag, " sclk idle"}, 32'(sclk_o), 32'(v.cpol));
        prev = v.cpol;
        for (int cyc = 0; cyc < 3000 && !got; cyc++) begin
            if (cyc > 0) @(negedge clk_i);
            if (!cs_n_o) cslow++;
            if (sclk_o !== prev) begin
                edges++;
                prev = sclk_o;
                if (((edges % 2) == 1) == (v.cpha == 1'b0)) begin
                    if (v.lsb) mw[sc] = mosi_o;
                    else       mw = {mw[6:0], mosi_o};
                    sc++;
                end else if (k < v.eff_l) begin
                    slave_miso = slave_bit(v, k);
                    k++;
                end
            end
            if (rx_valid_o) begin
                got = 1'b1;
                rx_cyc = cyc;
            end
        end
        check({tag, " rx_valid seen"}, 32'(got), 32'd1);
        check({tag, " rx_valid cycle"}, rx_cyc, v.exp_cslow);
        check({tag, " rx_data"}, 32'(rx_data_o), 32'(v.exp_rx));
        check({tag, " mosi bits"}, 32'(mw), 32'(v.exp_mosi));
        check({tag, " cs_n low cycles"}, cslow, v.exp_cslow);
        check({tag, " sclk edges"}, edges, v.exp_edges);
        @(negedge clk_i);
        check({tag, " rx_valid strobe"}, 32'(rx_valid_o), 32'd0);
    endtask

    logic [7:0] b2b[3];

    initial begin
        //              cpol  cpha  lsb   len    div    tx      pat     L  exp_rx exp_mosi cs  edges
        vecs[0] = '{1'b0, 1'b0, 1'b0, 4'd8,  8'd0, 8'hA5, 8'hA5, 8, 8'hA5, 8'hA5, 18, 16};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 4'd8,  8'd3, 8'h3C, 8'h81, 8, 8'h81, 8'h3C, 72, 16};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 4'd5,  8'd1, 8'h13, 8'h13, 5, 8'h13, 8'h13, 24, 10};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 4'd5,  8'd0, 8'h13, 8'h13, 5, 8'h13, 8'h13, 12, 10};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 4'd0,  8'd0, 8'h5A, 8'hC3, 8, 8'hC3, 8'h5A, 18, 16};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 4'd12, 8'd2, 8'h96, 8'h69, 8, 8'h69, 8'h96, 54, 16};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 4'd1,  8'd1, 8'h01, 8'h01, 1, 8'h01, 8'h01, 8,  2};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 4'd5,  8'd0, 8'hFF, 8'h0A, 5, 8'h0A, 8'h1F, 12, 10};
        b2b[0] = 8'h11; b2b[1] = 8'hE7; b2b[2] = 8'h5C;

        // Reset values.
        repeat (3) @(negedge clk_i);
        check("rst sclk", 32'(sclk_o), 32'd0);
        check("rst cs_n", 32'(cs_n_o), 32'd1);
        check("rst mosi", 32'(mosi_o), 32'd0);
        check("rst rx_data", 32'(rx_data_o), 32'd0);
        check("rst rx_valid", 32'(rx_valid_o), 32'd0);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst tx_ready", 32'(tx_ready_o), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_i);

        for (int i = 0; i < 8; i++) begin
            run_frame(i, vecs[i]);
        end

        // Back-to-back frames with tx_valid held high, MISO looped to MOSI.
        begin
            int frames, gap;
            logic seen_low;
            frames = 0; gap = 0; seen_low = 1'b0;
            @(negedge clk_i);
            loop_en = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0; lsb_first_i = 1'b0;
            len_i = 4'd8; clk_div_i = 8'd0; tx_data_i = b2b[0]; tx_valid_i = 1'b1;
            for (int cyc = 0; cyc < 1000 && frames < 3; cyc++) begin
                @(negedge clk_i);
                if (cs_n_o) begin
                    if (seen_low) gap++;
                end else begin
                    if (gap > 0) begin
                        check("b2b cs_n gap", gap, 1);
                        gap = 0;
                    end
                    seen_low = 1'b1;
                    tx_data_i = 8'($urandom); lsb_first_i = 1'b1; cpha_i = 1'b1;
                end
                if (rx_valid_o) begin
                    check($sformatf("b2b rx %0d", frames), 32'(rx_data_o), 32'(b2b[frames]));
                    check($sformatf("b2b ready %0d", frames), 32'(tx_ready_o), 32'd1);
                    frames++;
                    lsb_first_i = 1'b0; cpha_i = 1'b0;
                    if (frames < 3) tx_data_i = b2b[frames];
                    else            tx_valid_i = 1'b0;
                end
            end
            check("b2b frames", frames, 3);
            tx_valid_i = 1'b0;
            loop_en = 1'b0;
        end

        // Asynchronous reset in the middle of a frame.
        begin
            int nvalid;
            nvalid = 0;
            repeat (2) @(negedge clk_i);
            cpol_i = 1'b0; cpha_i = 1'b0; lsb_first_i = 1'b0; len_i = 4'd8;
            clk_div_i = 8'd1; tx_data_i = 8'hC3; tx_valid_i = 1'b1;
            @(negedge clk_i);
            tx_valid_i = 1'b0;
            repeat (16) @(negedge clk_i);
            check("pre-rst busy", 32'(busy_o), 32'd1);
            #2 rst_n = 1'b0;
            #1;
            check("arst cs_n", 32'(cs_n_o), 32'd1);
            check("arst sclk", 32'(sclk_o), 32'd0);
            check("arst busy", 32'(busy_o), 32'd0);
            check("arst ready", 32'(tx_ready_o), 32'd1);
            repeat (2) @(negedge clk_i);
            rst_n = 1'b1;
            for (int cyc = 0; cyc < 60; cyc++) begin
                @(negedge clk_i);
                if (rx_valid_o) nvalid++;
            end
            check("arst no rx_valid", nvalid, 0);
            run_frame(99, vecs[0]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
